// File: rtl/student_i2s_transceiver.sv
// Master-mode I2S serial port for the ADAU1761 codec (codec serial port runs as slave).
// Generates BCLK and LRCLK from clk_i, serialises DAC sample pairs and deserialises
// ADC sample pairs. All logic runs on clk_i; BCLK edges are clock-enable events.
//
// Ports:
//   clk_i, rst_ni           system clock, asynchronous active-low reset
//   en_i                    run enable (codec init done)
//   bclk_o, lrclk_o         bit clock and word select (0 = left, 1 = right)
//   sdata_o / sdata_i       DAC serial data out / ADC serial data in (pre-synchronised)
//   tx_l_i, tx_r_i          DAC sample pair, accepted on tx_valid_i && tx_ready_o
//   tx_ready_o              holding register empty
//   tx_underrun_o           1-cycle pulse: frame started without a new DAC pair
//   rx_l_o, rx_r_o          last received ADC pair
//   rx_valid_o              1-cycle pulse when rx_l_o/rx_r_o are updated
module student_i2s_transceiver #(
  parameter int unsigned DATA_W   = 24,
  parameter int unsigned SLOT_W   = 32,
  parameter int unsigned BCLK_DIV = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  output logic              bclk_o,
  output logic              lrclk_o,
  output logic              sdata_o,
  input  logic              sdata_i,
  input  logic [DATA_W-1:0] tx_l_i,
  input  logic [DATA_W-1:0] tx_r_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic              tx_underrun_o,
  output logic [DATA_W-1:0] rx_l_o,
  output logic [DATA_W-1:0] rx_r_o,
  output logic              rx_valid_o
);

  localparam int unsigned FrameBits = 2 * SLOT_W;
  localparam int unsigned BitW      = $clog2(FrameBits);
  localparam int unsigned DivW      = $clog2(BCLK_DIV);
  localparam logic [DivW-1:0] DivLast = DivW'(BCLK_DIV - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(FrameBits - 1);

  // Word select leads the slot by one bit (I2S one-bit delay).
  function automatic logic lr_of(input logic [BitW-1:0] b);
    int unsigned bi;
    bi = 32'(b);
    return (bi >= SLOT_W - 1) && (bi <= FrameBits - 2);
  endfunction

  // Serial bit for frame position b: MSB first, zero padding after DATA_W bits.
  function automatic logic tx_bit(input logic [BitW-1:0]   b,
                                  input logic [DATA_W-1:0] l,
                                  input logic [DATA_W-1:0] r);
    int unsigned      bi;
    int unsigned      k;
    logic [DATA_W-1:0] w;
    bi = 32'(b);
    if (bi >= SLOT_W) begin
      k = bi - SLOT_W;
      w = r;
    end else begin
      k = bi;
      w = l;
    end
    if (k >= DATA_W) begin
      return 1'b0;
    end
    w = w << k;
    return w[DATA_W-1];
  endfunction

  logic              en_q;
  logic [DivW-1:0]   div_q, div_d;
  logic              bclk_q, bclk_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic              lrclk_q, lrclk_d;
  logic              sdata_q, sdata_d;
  logic [DATA_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic              hold_full_q, hold_full_d;
  logic [DATA_W-1:0] tx_word_l_q, tx_word_l_d, tx_word_r_q, tx_word_r_d;
  logic              underrun_q, underrun_d;
  logic [DATA_W-1:0] rx_l_sh_q, rx_l_sh_d, rx_r_sh_q, rx_r_sh_d;
  logic [DATA_W-1:0] rx_l_q, rx_l_d, rx_r_q, rx_r_d;
  logic              rx_valid_q, rx_valid_d;

  logic        start, tick, rise, fall, frame_start;
  logic        cur_right;
  int unsigned cur_k;

  always_comb begin
    cur_right = 32'(bit_q) >= SLOT_W;
    cur_k     = cur_right ? 32'(bit_q) - SLOT_W : 32'(bit_q);

    start       = en_i && !en_q;
    tick        = en_i && (div_q == DivLast);
    rise        = tick && !bclk_q;
    fall        = tick && bclk_q;
    frame_start = start || (fall && (bit_q == BitLast));

    div_d       = div_q;
    bclk_d      = bclk_q;
    bit_d       = bit_q;
    lrclk_d     = lrclk_q;
    sdata_d     = sdata_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    hold_full_d = hold_full_q;
    tx_word_l_d = tx_word_l_q;
    tx_word_r_d = tx_word_r_q;
    underrun_d  = 1'b0;
    rx_l_sh_d   = rx_l_sh_q;
    rx_r_sh_d   = rx_r_sh_q;
    rx_l_d      = rx_l_q;
    rx_r_d      = rx_r_q;
    rx_valid_d  = 1'b0;

    if (!en_i) begin
      // Stop the link; holding register and last RX pair survive.
      div_d     = '0;
      bclk_d    = 1'b0;
      bit_d     = '0;
      lrclk_d   = 1'b0;
      sdata_d   = 1'b0;
      rx_l_sh_d = '0;
      rx_r_sh_d = '0;
    end else begin
      div_d = tick ? '0 : div_q + 1'b1;
      if (tick) begin
        bclk_d = !bclk_q;
      end

      if (start) begin
        bit_d = '0;
      end else if (fall) begin
        bit_d = (bit_q == BitLast) ? '0 : bit_q + 1'b1;
      end

      // The holding register keeps its data after being emptied, so copying it
      // unconditionally repeats the previous pair on underrun.
      if (frame_start) begin
        tx_word_l_d = hold_l_q;
        tx_word_r_d = hold_r_q;
        hold_full_d = 1'b0;
        underrun_d  = !hold_full_q;
      end

      if (start || fall) begin
        lrclk_d = lr_of(bit_d);
        sdata_d = tx_bit(bit_d, tx_word_l_d, tx_word_r_d);
      end

      if (rise && (cur_k < DATA_W)) begin
        if (cur_right) begin
          rx_r_sh_d    = rx_r_sh_q << 1;
          rx_r_sh_d[0] = sdata_i;
          if (cur_k == DATA_W - 1) begin
            rx_l_d     = rx_l_sh_q;
            rx_r_d     = rx_r_sh_d;
            rx_valid_d = 1'b1;
          end
        end else begin
          rx_l_sh_d    = rx_l_sh_q << 1;
          rx_l_sh_d[0] = sdata_i;
        end
      end
    end

    // Handshake last: a load coinciding with frame start refills the register
    // right after its old content moved to the shifter.
    if (tx_valid_i && !hold_full_q) begin
      hold_l_d    = tx_l_i;
      hold_r_d    = tx_r_i;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_q        <= 1'b0;
      div_q       <= '0;
      bclk_q      <= 1'b0;
      bit_q       <= '0;
      lrclk_q     <= 1'b0;
      sdata_q     <= 1'b0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      hold_full_q <= 1'b0;
      tx_word_l_q <= '0;
      tx_word_r_q <= '0;
      underrun_q  <= 1'b0;
      rx_l_sh_q   <= '0;
      rx_r_sh_q   <= '0;
      rx_l_q      <= '0;
      rx_r_q      <= '0;
      rx_valid_q  <= 1'b0;
    end else begin
      en_q        <= en_i;
      div_q       <= div_d;
      bclk_q      <= bclk_d;
      bit_q       <= bit_d;
      lrclk_q     <= lrclk_d;
      sdata_q     <= sdata_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      hold_full_q <= hold_full_d;
      tx_word_l_q <= tx_word_l_d;
      tx_word_r_q <= tx_word_r_d;
      underrun_q  <= underrun_d;
      rx_l_sh_q   <= rx_l_sh_d;
      rx_r_sh_q   <= rx_r_sh_d;
      rx_l_q      <= rx_l_d;
      rx_r_q      <= rx_r_d;
      rx_valid_q  <= rx_valid_d;
    end
  end

  assign bclk_o        = bclk_q;
  assign lrclk_o       = lrclk_q;
  assign sdata_o       = sdata_q;
  assign tx_ready_o    = !hold_full_q;
  assign tx_underrun_o = underrun_q;
  assign rx_l_o        = rx_l_q;
  assign rx_r_o        = rx_r_q;
  assign rx_valid_o    = rx_valid_q;

endmodule

// File: tb/tb_student_i2s_transceiver.sv
// Bench for student_i2s_transceiver: a default instance (24/32/16) and a small
// instance (16/16/2), both with sdata looped back. Expected RX pairs are queued
// when stimulus is driven and compared when rx_valid_o pulses.
module tb_student_i2s_transceiver;

  localparam int DW   = 24;
  localparam int SW   = 32;
  localparam int DIV  = 16;
  localparam int SDW  = 16;
  localparam int SSW  = 16;
  localparam int SDIV = 2;

  typedef struct packed {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
  } pair_t;

  typedef struct packed {
    logic [SDW-1:0] l;
    logic [SDW-1:0] r;
  } pair_s_t;

  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  int cyc = 0;
  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  // Default instance
  logic          en_i, bclk_o, lrclk_o, sdata_o;
  logic [DW-1:0] tx_l_i, tx_r_i, rx_l_o, rx_r_o;
  logic          tx_valid_i, tx_ready_o, tx_underrun_o, rx_valid_o;

  student_i2s_transceiver #(
    .DATA_W  (DW),
    .SLOT_W  (SW),
    .BCLK_DIV(DIV)
  ) u_dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .en_i         (en_i),
    .bclk_o       (bclk_o),
    .lrclk_o      (lrclk_o),
    .sdata_o      (sdata_o),
    .sdata_i      (sdata_o),
    .tx_l_i       (tx_l_i),
    .tx_r_i       (tx_r_i),
    .tx_valid_i   (tx_valid_i),
    .tx_ready_o   (tx_ready_o),
    .tx_underrun_o(tx_underrun_o),
    .rx_l_o       (rx_l_o),
    .rx_r_o       (rx_r_o),
    .rx_valid_o   (rx_valid_o)
  );

  // Small instance
  logic           en_s, bclk_s, lrclk_s, sdata_s;
  logic [SDW-1:0] tx_l_s, tx_r_s, rx_l_s, rx_r_s;
  logic           tx_valid_s, ready_s, underrun_s, rx_valid_s;

  student_i2s_transceiver #(
    .DATA_W  (SDW),
    .SLOT_W  (SSW),
    .BCLK_DIV(SDIV)
  ) u_dut_s (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .en_i         (en_s),
    .bclk_o       (bclk_s),
    .lrclk_o      (lrclk_s),
    .sdata_o      (sdata_s),
    .sdata_i      (sdata_s),
    .tx_l_i       (tx_l_s),
    .tx_r_i       (tx_r_s),
    .tx_valid_i   (tx_valid_s),
    .tx_ready_o   (ready_s),
    .tx_underrun_o(underrun_s),
    .rx_l_o       (rx_l_s),
    .rx_r_o       (rx_r_s),
    .rx_valid_o   (rx_valid_s)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  pair_t   sb[$];
  pair_s_t sb_s[$];
  bit      mon_en = 1'b0;
  int      und_cnt = 0;

  // Default-instance monitor
  logic        bclk_p = 1'b0, lr_p = 1'b0;
  logic [63:0] cap = '0;
  int          bclk_t = -1, lr_rise_t = -1;
  pair_t       e;

  initial forever begin
    @(negedge clk_i);
    if (bclk_o && !bclk_p) begin
      cap = {cap[62:0], sdata_o};
      if (mon_en && bclk_t >= 0) check_eq("bclk_period", 64'(cyc - bclk_t), 64'(2 * DIV));
      bclk_t = cyc;
    end
    if (mon_en && (lrclk_o != lr_p)) begin
      check_eq("lr_on_bclk_fall", 64'({bclk_p, bclk_o}), 64'(2'b10));
      if (lrclk_o) begin
        if (lr_rise_t >= 0) check_eq("lr_period", 64'(cyc - lr_rise_t), 64'(4 * SW * DIV));
        lr_rise_t = cyc;
      end else if (lr_rise_t >= 0) begin
        check_eq("lr_high_time", 64'(cyc - lr_rise_t), 64'(2 * SW * DIV));
      end
    end
    if (tx_underrun_o) und_cnt++;
    if (rx_valid_o) begin
      if (sb.size() == 0) begin
        check_eq("rx_unexpected", 64'(rx_valid_o), 64'(0));
      end else begin
        e = sb.pop_front();
        check_eq("rx_l", 64'(rx_l_o), 64'(e.l));
        check_eq("rx_r", 64'(rx_r_o), 64'(e.r));
        check_eq("tx_stream", 64'(cap[55:0]), 64'({e.l, 8'h00, e.r}));
      end
    end
    if (!mon_en) begin
      bclk_t    = -1;
      lr_rise_t = -1;
    end
    bclk_p = bclk_o;
    lr_p   = lrclk_o;
  end

  // Small-instance monitor
  logic        bclk_s_p = 1'b0;
  logic [31:0] cap_s = '0;
  int          bclk_s_t = -1, rx_s_t = -1;
  pair_s_t     es;

  initial forever begin
    @(negedge clk_i);
    if (bclk_s && !bclk_s_p) begin
      cap_s = {cap_s[30:0], sdata_s};
      if (en_s && bclk_s_t >= 0) check_eq("s_bclk_period", 64'(cyc - bclk_s_t), 64'(2 * SDIV));
      bclk_s_t = cyc;
    end
    if (rx_valid_s) begin
      if (sb_s.size() == 0) begin
        check_eq("s_rx_unexpected", 64'(rx_valid_s), 64'(0));
      end else begin
        es = sb_s.pop_front();
        check_eq("s_rx_l", 64'(rx_l_s), 64'(es.l));
        check_eq("s_rx_r", 64'(rx_r_s), 64'(es.r));
        check_eq("s_tx_stream", 64'(cap_s), 64'({es.l, es.r}));
        if (rx_s_t >= 0) check_eq("s_frame_len", 64'(cyc - rx_s_t), 64'(4 * SSW * SDIV));
        rx_s_t = cyc;
      end
    end
    if (!en_s) bclk_s_t = -1;
    bclk_s_p = bclk_s;
  end

  task automatic wait_sb(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    check_eq("sb_drain", 64'(sb.size()), 64'(0));
  endtask

  task automatic wait_sb_s(input int budget);
    int n = 0;
    while (sb_s.size() != 0 && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    check_eq("s_sb_drain", 64'(sb_s.size()), 64'(0));
  endtask

  pair_t   pa, pb, pc;
  pair_s_t ps;

  initial begin
    int n;
    pa = '{l: 24'hABCDEF, r: 24'h123456};
    pb = '{l: 24'h654321, r: 24'hFEDCBA};
    pc = '{l: 24'hC0FFEE, r: 24'h0F1E2D};
    ps = '{l: 16'h8001, r: 16'h7FFE};

    rst_ni = 1'b0;
    en_i = 1'b0; tx_valid_i = 1'b0; tx_l_i = '0; tx_r_i = '0;
    en_s = 1'b0; tx_valid_s = 1'b0; tx_l_s = '0; tx_r_s = '0;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    check_eq("rst_bclk", 64'(bclk_o), 64'(0));
    check_eq("rst_lrclk", 64'(lrclk_o), 64'(0));
    check_eq("rst_sdata", 64'(sdata_o), 64'(0));
    check_eq("rst_rx_valid", 64'(rx_valid_o), 64'(0));
    check_eq("rst_underrun", 64'(tx_underrun_o), 64'(0));
    check_eq("rst_rx_l", 64'(rx_l_o), 64'(0));
    check_eq("rst_rx_r", 64'(rx_r_o), 64'(0));
    check_eq("rst_tx_ready", 64'(tx_ready_o), 64'(1));

    // Small configuration: one loaded pair, sent twice (second frame repeats it).
    tx_l_s = ps.l; tx_r_s = ps.r; tx_valid_s = 1'b1;
    @(negedge clk_i);
    tx_valid_s = 1'b0;
    check_eq("s_ready_after_load", 64'(ready_s), 64'(0));
    sb_s.push_back(ps);
    sb_s.push_back(ps);
    en_s = 1'b1;
    wait_sb_s(600);
    en_s = 1'b0;

    // Pair A loaded while idle, then B offered and held.
    tx_l_i = pa.l; tx_r_i = pa.r; tx_valid_i = 1'b1;
    @(negedge clk_i);
    tx_l_i = pb.l; tx_r_i = pb.r;
    check_eq("ready_after_load", 64'(tx_ready_o), 64'(0));
    repeat (5) @(negedge clk_i);
    check_eq("ready_while_full", 64'(tx_ready_o), 64'(0));

    sb.push_back(pa);
    sb.push_back(pb);
    sb.push_back(pb);
    mon_en = 1'b1;
    en_i = 1'b1;
    @(negedge clk_i);
    check_eq("ready_at_start", 64'(tx_ready_o), 64'(1));
    check_eq("underrun_at_start", 64'(tx_underrun_o), 64'(0));
    check_eq("lrclk_at_start", 64'(lrclk_o), 64'(0));
    check_eq("sdata_first_msb", 64'(sdata_o), 64'(pa.l[DW-1]));
    @(negedge clk_i);
    check_eq("ready_after_b_load", 64'(tx_ready_o), 64'(0));
    tx_valid_i = 1'b0;

    wait_sb(3 * 2048 + 200);
    check_eq("underrun_count_f3", 64'(und_cnt), 64'(1));

    n = 0;
    while (und_cnt < 2 && n < 2200) begin
      @(negedge clk_i);
      n++;
    end
    check_eq("underrun_count_f4", 64'(und_cnt), 64'(2));

    // Load C, then drop enable mid-frame at b=40.
    tx_l_i = pc.l; tx_r_i = pc.r; tx_valid_i = 1'b1;
    @(negedge clk_i);
    tx_valid_i = 1'b0;
    check_eq("ready_after_c_load", 64'(tx_ready_o), 64'(0));
    n = 0;
    while (!lrclk_o && n < 2200) begin
      @(negedge clk_i);
      n++;
    end
    check_eq("lr_rise_seen", 64'(lrclk_o), 64'(1));
    repeat (9 * 2 * DIV + DIV) @(negedge clk_i);
    check_eq("lr_at_b40", 64'(lrclk_o), 64'(1));
    mon_en = 1'b0;
    en_i = 1'b0;
    @(negedge clk_i);
    check_eq("dis_bclk", 64'(bclk_o), 64'(0));
    check_eq("dis_lrclk", 64'(lrclk_o), 64'(0));
    check_eq("dis_sdata", 64'(sdata_o), 64'(0));
    check_eq("dis_ready_kept", 64'(tx_ready_o), 64'(0));
    check_eq("dis_rx_l_kept", 64'(rx_l_o), 64'(pb.l));
    check_eq("dis_rx_r_kept", 64'(rx_r_o), 64'(pb.r));
    repeat (2500) @(negedge clk_i);
    check_eq("dis_idle_bclk", 64'(bclk_o), 64'(0));
    check_eq("underrun_count_idle", 64'(und_cnt), 64'(2));

    // Re-enable: restart at b=0 with the retained pair C.
    en_i = 1'b1;
    @(negedge clk_i);
    check_eq("re_lrclk", 64'(lrclk_o), 64'(0));
    check_eq("re_sdata_msb", 64'(sdata_o), 64'(pc.l[DW-1]));
    check_eq("re_ready", 64'(tx_ready_o), 64'(1));
    check_eq("re_underrun", 64'(tx_underrun_o), 64'(0));
    sb.push_back(pc);
    mon_en = 1'b1;
    wait_sb(2200);
    check_eq("underrun_count_end", 64'(und_cnt), 64'(2));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
